// File: rtl/axi_write_stim_driver.sv
// Command-driven AXI write burst generator: one command yields a complete AW -> W -> B
// transaction with an incrementing data pattern, per-beat byte strobes and response capture.
`timescale 1ns/1ps
module axi_write_stim_driver #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [7:0]    cmd_len,
  input  logic [2:0]    cmd_size,
  input  logic [1:0]    cmd_burst,
  input  logic [63:0]   cmd_seed,
  output logic [AW-1:0] awaddr_out,
  output logic [7:0]    awlen_out,
  output logic [2:0]    awsize_out,
  output logic [1:0]    awburst_out,
  output logic          awvalid_out,
  input  logic          awready_in,
  output logic [63:0]   wdata_out,
  output logic [7:0]    wstrb_out,
  output logic          wvalid_out,
  input  logic          wready_in,
  input  logic          bvalid_in,
  input  logic [1:0]    bresp_in,
  output logic          bready_out,
  output logic          done,
  output logic [1:0]    last_bresp,
  output logic          err,
  output logic [15:0]   txn_count
);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_INCR  = 2'd1;
  localparam logic [1:0] MODE_WRAP  = 2'd2;

  state_t        state_reg, state_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [7:0]    len_reg, len_next;
  logic [1:0]    size_reg, size_next;
  logic [1:0]    burst_reg, burst_next;
  logic [1:0]    mode_reg, mode_next;
  logic [63:0]   seed_reg, seed_next;
  logic [7:0]    beat_reg, beat_next;
  logic [AW-1:0] beat_addr_reg, beat_addr_next;
  logic [63:0]   wdata_reg, wdata_next;
  logic [7:0]    wstrb_reg, wstrb_next;
  logic          cmd_ready_reg, cmd_ready_next;
  logic          awvalid_reg, awvalid_next;
  logic          wvalid_reg, wvalid_next;
  logic          bready_reg, bready_next;
  logic          done_reg, done_next;
  logic [1:0]    last_bresp_reg, last_bresp_next;
  logic          err_reg, err_next;
  logic [15:0]   txn_count_reg, txn_count_next;

  logic [1:0]    size_clamped;
  logic          wrap_len_ok;
  logic [AW-1:0] beat_addr_adv;

  // Byte lanes covered by one beat: the low address bits aligned down to the beat size.
  function automatic logic [7:0] strobe_of(input logic [2:0] addr_lo, input logic [1:0] size);
    logic [7:0] mask;
    logic [2:0] lane;
    case (size)
      2'd0:    begin mask = 8'h01; lane = addr_lo;                 end
      2'd1:    begin mask = 8'h03; lane = {addr_lo[2:1], 1'b0};    end
      2'd2:    begin mask = 8'h0F; lane = {addr_lo[2], 2'b00};     end
      default: begin mask = 8'hFF; lane = 3'd0;                    end
    endcase
    return mask << lane;
  endfunction

  function automatic logic [AW-1:0] advance_addr(input logic [AW-1:0] addr, input logic [1:0] size,
                                                 input logic [7:0] len, input logic [1:0] mode);
    logic [AW-1:0] nbytes, aligned, incr, span, base, result;
    nbytes  = AW'(1) << size;
    aligned = addr & ~(nbytes - AW'(1));
    incr    = aligned + nbytes;
    span    = AW'({1'b0, len} + 9'd1) << size;
    base    = addr & ~(span - AW'(1));
    case (mode)
      MODE_FIXED: result = addr;
      MODE_WRAP:  result = (incr == base + span) ? base : incr;
      default:    result = incr;
    endcase
    return result;
  endfunction

  assign size_clamped  = (cmd_size > 3'd3) ? 2'd3 : cmd_size[1:0];
  assign wrap_len_ok   = (cmd_len == 8'd1) || (cmd_len == 8'd3) || (cmd_len == 8'd7) || (cmd_len == 8'd15);
  assign beat_addr_adv = advance_addr(beat_addr_reg, size_reg, len_reg, mode_reg);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      addr_reg       <= '0;
      len_reg        <= '0;
      size_reg       <= '0;
      burst_reg      <= '0;
      mode_reg       <= '0;
      seed_reg       <= '0;
      beat_reg       <= '0;
      beat_addr_reg  <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
      cmd_ready_reg  <= 1'b0;
      awvalid_reg    <= 1'b0;
      wvalid_reg     <= 1'b0;
      bready_reg     <= 1'b0;
      done_reg       <= 1'b0;
      last_bresp_reg <= '0;
      err_reg        <= 1'b0;
      txn_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      len_reg        <= len_next;
      size_reg       <= size_next;
      burst_reg      <= burst_next;
      mode_reg       <= mode_next;
      seed_reg       <= seed_next;
      beat_reg       <= beat_next;
      beat_addr_reg  <= beat_addr_next;
      wdata_reg      <= wdata_next;
      wstrb_reg      <= wstrb_next;
      cmd_ready_reg  <= cmd_ready_next;
      awvalid_reg    <= awvalid_next;
      wvalid_reg     <= wvalid_next;
      bready_reg     <= bready_next;
      done_reg       <= done_next;
      last_bresp_reg <= last_bresp_next;
      err_reg        <= err_next;
      txn_count_reg  <= txn_count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    len_next        = len_reg;
    size_next       = size_reg;
    burst_next      = burst_reg;
    mode_next       = mode_reg;
    seed_next       = seed_reg;
    beat_next       = beat_reg;
    beat_addr_next  = beat_addr_reg;
    wdata_next      = wdata_reg;
    wstrb_next      = wstrb_reg;
    cmd_ready_next  = cmd_ready_reg;
    awvalid_next    = awvalid_reg;
    wvalid_next     = wvalid_reg;
    bready_next     = bready_reg;
    done_next       = 1'b0;
    last_bresp_next = last_bresp_reg;
    err_next        = err_reg;
    txn_count_next  = txn_count_reg;

    case (state_reg)
      S_IDLE: begin
        if (cmd_ready_reg && cmd_valid) begin
          addr_next      = cmd_addr;
          len_next       = cmd_len;
          size_next      = size_clamped;
          burst_next     = cmd_burst;
          seed_next      = cmd_seed;
          // WRAP with an illegal length and the reserved encoding both run as INCR.
          if (cmd_burst == 2'd0)
            mode_next = MODE_FIXED;
          else if ((cmd_burst == 2'd2) && wrap_len_ok)
            mode_next = MODE_WRAP;
          else
            mode_next = MODE_INCR;
          cmd_ready_next = 1'b0;
          awvalid_next   = 1'b1;
          state_next     = S_AW;
        end else begin
          cmd_ready_next = 1'b1;
        end
      end
      S_AW: begin
        if (awready_in) begin
          awvalid_next   = 1'b0;
          wvalid_next    = 1'b1;
          beat_next      = 8'd0;
          beat_addr_next = addr_reg;
          wdata_next     = seed_reg;
          wstrb_next     = strobe_of(addr_reg[2:0], size_reg);
          state_next     = S_W;
        end
      end
      S_W: begin
        if (wready_in) begin
          if (beat_reg == len_reg) begin
            wvalid_next = 1'b0;
            bready_next = 1'b1;
            state_next  = S_B;
          end else begin
            beat_next      = beat_reg + 8'd1;
            beat_addr_next = beat_addr_adv;
            wdata_next     = seed_reg + {56'd0, beat_reg + 8'd1};
            wstrb_next     = strobe_of(beat_addr_adv[2:0], size_reg);
          end
        end
      end
      S_B: begin
        if (bvalid_in) begin
          bready_next     = 1'b0;
          last_bresp_next = bresp_in;
          err_next        = err_reg | (bresp_in != 2'b00);
          txn_count_next  = txn_count_reg + 16'd1;
          done_next       = 1'b1;
          cmd_ready_next  = 1'b1;
          state_next      = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign cmd_ready   = cmd_ready_reg;
  assign awaddr_out  = addr_reg;
  assign awlen_out   = len_reg;
  assign awsize_out  = {1'b0, size_reg};
  assign awburst_out = burst_reg;
  assign awvalid_out = awvalid_reg;
  assign wdata_out   = wdata_reg;
  assign wstrb_out   = wstrb_reg;
  assign wvalid_out  = wvalid_reg;
  assign bready_out  = bready_reg;
  assign done        = done_reg;
  assign last_bresp  = last_bresp_reg;
  assign err         = err_reg;
  assign txn_count   = txn_count_reg;

endmodule

// File: tb/tb_axi_write_stim_driver.sv
// Directed bench for axi_write_stim_driver: expected AW fields and W beats are queued when a
// command is issued and compared by a monitor as the handshakes occur.
`timescale 1ns/1ps
module tb_axi_write_stim_driver;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [1:0]    cmd_burst;
  logic [63:0]   cmd_seed;
  logic [AW-1:0] awaddr_out;
  logic [7:0]    awlen_out;
  logic [2:0]    awsize_out;
  logic [1:0]    awburst_out;
  logic          awvalid_out;
  logic          awready_in;
  logic [63:0]   wdata_out;
  logic [7:0]    wstrb_out;
  logic          wvalid_out;
  logic          wready_in;
  logic          bvalid_in;
  logic [1:0]    bresp_in;
  logic          bready_out;
  logic          done;
  logic [1:0]    last_bresp;
  logic          err;
  logic [15:0]   txn_count;

  axi_write_stim_driver #(.AW(AW)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_seed(cmd_seed),
    .awaddr_out(awaddr_out), .awlen_out(awlen_out), .awsize_out(awsize_out),
    .awburst_out(awburst_out), .awvalid_out(awvalid_out), .awready_in(awready_in),
    .wdata_out(wdata_out), .wstrb_out(wstrb_out), .wvalid_out(wvalid_out), .wready_in(wready_in),
    .bvalid_in(bvalid_in), .bresp_in(bresp_in), .bready_out(bready_out),
    .done(done), .last_bresp(last_bresp), .err(err), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } aw_exp_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
  } w_exp_t;

  aw_exp_t     aw_q[$];
  w_exp_t      w_q[$];
  aw_exp_t     aw_e;
  w_exp_t      w_e;
  int          errors = 0;
  int          checks = 0;
  int          w_hs = 0;
  int          txn_no = 0;
  logic [15:0] exp_txn = '0;
  logic        exp_err = 1'b0;
  logic [1:0]  exp_bresp = '0;
  logic        prev_aw_stall = 1'b0;
  logic        prev_w_stall = 1'b0;
  logic [AW-1:0] prev_awaddr;
  logic [63:0] prev_wdata;
  logic [7:0]  prev_wstrb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference beat model: AXI address sequence written as start/aligned/base + offset arithmetic.
  task automatic push_expect(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [63:0] seed);
    int          sz, nb, lane;
    logic [31:0] aligned, span, base, a;
    bit          fixed, wrap;
    logic [7:0]  strb;
    sz      = (size > 3'd3) ? 3 : int'(size);
    nb      = 1 << sz;
    aligned = addr & ~32'(nb - 1);
    fixed   = (burst == 2'd0);
    wrap    = (burst == 2'd2) && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    span    = 32'((int'(len) + 1) * nb);
    base    = addr - (addr % span);
    aw_q.push_back('{addr, len, 3'(sz), burst});
    for (int i = 0; i <= int'(len); i++) begin
      if (i == 0 || fixed)
        a = addr;
      else if (wrap)
        a = base + ((aligned + 32'(i * nb) - base) % span);
      else
        a = aligned + 32'(i * nb);
      lane = (int'(a[2:0]) / nb) * nb;
      strb = 8'(((1 << nb) - 1) << lane);
      w_q.push_back('{seed + 64'(i), strb});
    end
  endtask

  task automatic run_cmd(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [63:0] seed, input logic [1:0] bresp,
                         input int aw_stall, input bit w_toggle, input int exp_latency);
    int n, latency, aw_wait, hs0;
    push_expect(addr, len, size, burst, seed);
    hs0       = w_hs;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = size;
    cmd_burst = burst;
    cmd_seed  = seed;
    bresp_in  = bresp;
    bvalid_in = 1'b1;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    latency   = 1;
    aw_wait   = 0;
    while (!done && latency < 300) begin
      if (awvalid_out) begin
        awready_in = (aw_wait >= aw_stall);
        aw_wait++;
      end else begin
        awready_in = 1'b0;
      end
      wready_in = w_toggle ? ~wready_in : 1'b1;
      tick();
      latency++;
    end
    check("done_seen", done, 1);
    if (exp_latency != 0) check("latency", latency, exp_latency);
    exp_txn++;
    if (bresp != 2'b00) exp_err = 1'b1;
    exp_bresp = bresp;
    check("txn_count", txn_count, exp_txn);
    check("last_bresp", last_bresp, exp_bresp);
    check("err", err, exp_err);
    check("cmd_ready_after", cmd_ready, 1);
    check("beats", w_hs - hs0, int'(len) + 1);
    check("w_q_empty", w_q.size(), 0);
    txn_no++;
    $display("txn %0d: addr=0x%0h len=%0d size=%0d burst=%0d bresp=%0d latency=%0d beats=%0d",
             txn_no, addr, len, size, burst, bresp, latency, w_hs - hs0);
    tick();
    check("done_one_cycle", done, 0);
    awready_in = 1'b0;
    wready_in  = 1'b0;
  endtask

  // Monitor: scoreboard pops on handshakes, plus hold-stability and no-overlap checks.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_aw_stall = 1'b0;
      prev_w_stall  = 1'b0;
    end else begin
      if (prev_aw_stall) begin
        check("aw_hold_valid", awvalid_out, 1);
        check("aw_hold_addr", awaddr_out, prev_awaddr);
      end
      if (prev_w_stall) begin
        check("w_hold_valid", wvalid_out, 1);
        check("w_hold_data", wdata_out, prev_wdata);
        check("w_hold_strb", wstrb_out, prev_wstrb);
      end
      check("aw_w_overlap", awvalid_out & wvalid_out, 0);
      if (awvalid_out && awready_in) begin
        check("aw_expected", aw_q.size() != 0, 1);
        if (aw_q.size() != 0) begin
          aw_e = aw_q.pop_front();
          check("awaddr", awaddr_out, aw_e.addr);
          check("awlen", awlen_out, aw_e.len);
          check("awsize", awsize_out, aw_e.size);
          check("awburst", awburst_out, aw_e.burst);
        end
      end
      if (wvalid_out && wready_in) begin
        w_hs++;
        check("w_expected", w_q.size() != 0, 1);
        if (w_q.size() != 0) begin
          w_e = w_q.pop_front();
          check("wdata", wdata_out, w_e.data);
          check("wstrb", wstrb_out, w_e.strb);
        end
      end
      prev_aw_stall = awvalid_out && !awready_in;
      prev_w_stall  = wvalid_out && !wready_in;
      prev_awaddr   = awaddr_out;
      prev_wdata    = wdata_out;
      prev_wstrb    = wstrb_out;
    end
  end

  initial begin
    resetn     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_size   = '0;
    cmd_burst  = '0;
    cmd_seed   = '0;
    awready_in = 1'b0;
    wready_in  = 1'b0;
    bvalid_in  = 1'b0;
    bresp_in   = '0;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", awvalid_out, 0);
    check("rst_wvalid", wvalid_out, 0);
    check("rst_bready", bready_out, 0);
    check("rst_done", done, 0);
    check("rst_txn_count", txn_count, 0);
    check("rst_err", err, 0);
    check("rst_wstrb", wstrb_out, 0);
    resetn = 1'b1;
    tick();
    tick();
    check("idle_cmd_ready", cmd_ready, 1);

    run_cmd(32'h1000, 8'd3, 3'd3, 2'd1, 64'h10, 2'd0, 0, 1'b0, 7);
    run_cmd(32'h2001, 8'd3, 3'd0, 2'd1, 64'hA5, 2'd0, 0, 1'b0, 7);
    run_cmd(32'h3018, 8'd3, 3'd3, 2'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2'd0, 0, 1'b0, 7);
    run_cmd(32'h4004, 8'd2, 3'd2, 2'd2, 64'h1234_5678_0000_0000, 2'd0, 0, 1'b0, 6);
    run_cmd(32'h5003, 8'd7, 3'd5, 2'd3, 64'hDEAD_0000, 2'd0, 3, 1'b1, 0);
    run_cmd(32'h6006, 8'd3, 3'd1, 2'd0, 64'h77, 2'd0, 3, 1'b1, 0);
    run_cmd(32'h7000, 8'd1, 3'd3, 2'd1, 64'h100, 2'd2, 0, 1'b0, 5);
    run_cmd(32'h7100, 8'd1, 3'd3, 2'd1, 64'h200, 2'd0, 0, 1'b0, 5);

    // Abandon a transaction mid-W with an asynchronous reset.
    push_expect(32'h8000, 8'd7, 3'd3, 2'd1, 64'h300);
    cmd_addr   = 32'h8000;
    cmd_len    = 8'd7;
    cmd_size   = 3'd3;
    cmd_burst  = 2'd1;
    cmd_seed   = 64'h300;
    bresp_in   = 2'd0;
    bvalid_in  = 1'b1;
    awready_in = 1'b1;
    wready_in  = 1'b1;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("pre_reset_wvalid", wvalid_out, 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_awvalid", awvalid_out, 0);
    check("mid_rst_wvalid", wvalid_out, 0);
    check("mid_rst_wdata", wdata_out, 0);
    check("mid_rst_wstrb", wstrb_out, 0);
    check("mid_rst_awaddr", awaddr_out, 0);
    check("mid_rst_bready", bready_out, 0);
    check("mid_rst_txn_count", txn_count, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_last_bresp", last_bresp, 0);
    tick();
    tick();
    check("mid_rst_no_done", done, 0);
    resetn = 1'b1;
    aw_q.delete();
    w_q.delete();
    exp_txn    = '0;
    exp_err    = 1'b0;
    awready_in = 1'b0;
    wready_in  = 1'b0;
    tick();
    check("post_rst_no_done", done, 0);
    run_cmd(32'h9000, 8'd3, 3'd3, 2'd1, 64'h400, 2'd0, 0, 1'b0, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_write_stim_driver.md
# axi_write_stim_driver

Command-driven AXI write burst generator that sits directly upstream of the write-channel master/slave pair. It drives that stage's address, data and response-ready inputs and observes the returned ready/valid/response signals. A single command produces one complete AW→W→B transaction: the address phase, a self-generated incrementing data pattern with per-beat byte strobes, then response capture. Used as the stimulus source in write-path verification tops.

## Interface
- AW, 32, address width
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle and able to accept a command
- cmd_addr  in  AW  burst start address
- cmd_len  in  8  beats minus one
- cmd_size  in  3  log2 bytes per beat; values >3 clamp to 3
- cmd_burst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 treated as INCR
- cmd_seed  in  64  data value of beat 0
- awaddr_out, awlen_out, awsize_out, awburst_out  out  AW/8/3/2  registered command fields (size post-clamp)
- awvalid_out  out  1  address valid
- awready_in  in  1  address ready from downstream
- wdata_out  out  64  beat data
- wstrb_out  out  8  beat byte strobes
- wvalid_out  out  1  data valid
- wready_in  in  1  data ready from downstream
- bvalid_in  in  1  response valid
- bresp_in  in  2  response code
- bready_out  out  1  response ready
- done  out  1  one-cycle pulse on response handshake
- last_bresp  out  2  bresp captured at last response
- err  out  1  sticky; set when any bresp ≠ 0
- txn_count  out  16  completed transactions, wraps at 0xFFFF→0

## Operation
- Reset (async, resetn=0): state IDLE; every output 0; internal beat counter and beat address 0. Reset mid-transaction abandons it, with no done pulse.
- States: IDLE → AW → W → B → IDLE.
- IDLE: cmd_ready=1. When cmd_valid=1, latch all cmd_* fields and go to AW.
- AW: awvalid_out=1 and aw* fields stable until awvalid_out&&awready_in. Go to W; beat=0, beat address=cmd_addr.
- W: wvalid_out=1; wdata_out = seed + beat (64-bit wrap). A beat completes on wvalid_out&&wready_in; on completion beat increments and the beat address advances. The last beat is beat==len; its completion goes to B. Data and strobe hold stable while wready_in=0.
- Strobe: nbytes=1<<size; lane = beat address[2:0] aligned down to nbytes; wstrb_out = ((1<<nbytes)-1)<<lane. Size 3 gives 0xFF.
- Address advance:
  - FIXED: unchanged.
  - INCR: aligned address + nbytes.
  - WRAP: wrap span = (len+1)*nbytes; the next address wraps to the span-aligned base on reaching base+span. A WRAP with len∉{1,3,7,15} is executed as INCR.
- B: bready_out=1. On bvalid_in&&bready_out: last_bresp←bresp_in; err|=(bresp_in≠0); txn_count+1; done=1 for one cycle; go to IDLE.
- bvalid_in, awready_in and wready_in outside their own state are ignored.

## Timing
- The command accept cycle is T. awvalid_out is first high at T+1.
- The AW handshake at cycle A gives wvalid_out high at A+1. W never overlaps AW.
- With wready_in held 1, beats complete on consecutive cycles. The last beat handshake at L gives bready_out high at L+1.
- The B handshake at R gives done=1, cmd_ready=1 and updated counters at R+1. A command offered at R+1 is accepted that cycle.
- Minimum transaction with all readies held 1 and bvalid_in held 1: len+4 cycles accept-to-done.
- All outputs are registered. None depends combinationally on awready_in, wready_in or bvalid_in.

## Test plan
- INCR, addr 0x1000, len 3, size 3, seed 0x10, all readies 1 → awaddr 0x1000, four beats 0x10–0x13, wstrb 0xFF each, done 7 cycles after accept, txn_count=1.
- Narrow INCR, addr 0x2001, len 3, size 0 → wstrb 0x02, 0x04, 0x08, 0x10.
- WRAP, addr 0x3018, len 3, size 3 → beat addresses 0x3018, 0x3000, 0x3008, 0x3010; all wstrb 0xFF.
- Backpressure: awready_in low 3 cycles, wready_in toggling → awvalid/aw* stable, wdata/wstrb held across stalls, exactly len+1 handshakes.
- bresp_in=2 on txn 1, then 0 on txn 2 → err=1 stays set, last_bresp=0 after txn 2.
- resetn pulsed low mid-W → all outputs 0 immediately, no done, next command runs normally from IDLE.
